// File: rtl/gate_mac_seq_if.sv
// rtl/gate_mac_seq_if.sv - element/result handshake bundle for the gate pre-activation MAC
interface gate_mac_seq_if #(
    parameter int DATA_WIDTH = 8
);
    logic                         start;
    logic signed [DATA_WIDTH-1:0] bias;
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_data;
    logic signed [DATA_WIDTH-1:0] in_weight;
    logic                         in_seg;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_ovf;

    modport master (
        output start, bias, in_valid, in_data, in_weight, out_ready,
        input  in_ready, in_seg, out_valid, out_data, out_ovf
    );

    modport slave (
        input  start, bias, in_valid, in_data, in_weight, out_ready,
        output in_ready, in_seg, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/gate_mac_seq.sv
// rtl/gate_mac_seq.sv - sequential W.{x,h}+b gate pre-activation, one MAC per cycle, saturated
module gate_mac_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int FRACT_WIDTH = 5,
    parameter int N_X         = 4,
    parameter int N_H         = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    gate_mac_seq_if.slave bus
);
    localparam int N     = N_X + N_H;
    localparam int CNT_W = $clog2(N + 1);
    localparam int ACC_W = 2 * DATA_WIDTH + CNT_W;
    localparam int DW    = DATA_WIDTH;

    localparam logic [CNT_W-1:0] LAST_C = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] NX_C   = CNT_W'(N_X);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    in_ready_q, in_ready_d;
    logic                    in_seg_q, in_seg_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [DW-1:0]    out_data_q, out_data_d;
    logic                    out_ovf_q, out_ovf_d;

    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] bias_acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] rescaled;
    logic signed [DW-1:0]    sat_data;
    logic                    sat_ovf;

    always_comb begin
        prod     = $signed({{DW{bus.in_data[DW-1]}}, bus.in_data}) *
                   $signed({{DW{bus.in_weight[DW-1]}}, bus.in_weight});
        bias_acc = {{(ACC_W-DW){bus.bias[DW-1]}}, bus.bias} << FRACT_WIDTH;
        acc_sum  = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
        // Floor rescale: arithmetic shift, no rounding term.
        rescaled = acc_sum >>> FRACT_WIDTH;
        sat_data = rescaled[DW-1:0];
        sat_ovf  = 1'b0;
        if (rescaled > SAT_MAX) begin
            sat_data = SAT_MAX[DW-1:0];
            sat_ovf  = 1'b1;
        end else if (rescaled < SAT_MIN) begin
            sat_data = SAT_MIN[DW-1:0];
            sat_ovf  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bias_acc;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_C) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = sat_data;
                        out_ovf_d   = sat_ovf;
                    end
                end
            end
            DONE: begin
                // A start coinciding with retirement chains straight into the next vector.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.start) begin
                        acc_d   = bias_acc;
                        cnt_d   = '0;
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == ACCUM);
        in_seg_d   = (state_d == ACCUM) && (cnt_d >= NX_C);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b0;
            in_seg_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            in_ready_q  <= in_ready_d;
            in_seg_q    <= in_seg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.in_seg    = in_seg_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_gate_mac_seq.sv
// tb/tb_gate_mac_seq.sv - randomized self-checking bench for gate_mac_seq against an arithmetic model
module tb_gate_mac_seq;
    localparam int DW  = 8;
    localparam int FW  = 5;
    localparam int NX  = 2;
    localparam int NH  = 2;
    localparam int N   = NX + NH;

    typedef int vec_t [N];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    gate_mac_seq_if #(.DATA_WIDTH(DW)) bus ();

    gate_mac_seq #(
        .DATA_WIDTH (DW),
        .FRACT_WIDTH(FW),
        .N_X        (NX),
        .N_H        (NH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // out = sat(floor((b*2^FW + sum d*w) / 2^FW))
    task automatic model(input int b, input vec_t d, input vec_t w, output int r, output int ovf);
        longint acc;
        longint q;
        acc = longint'(b) * (64'sd1 << FW);
        for (int i = 0; i < N; i++) acc += longint'(d[i]) * longint'(w[i]);
        q = acc / (64'sd1 << FW);
        if (acc < 0 && (acc % (64'sd1 << FW)) != 0) q = q - 1;
        ovf = 0;
        if (q > 127) begin
            q = 127;
            ovf = 1;
        end else if (q < -128) begin
            q = -128;
            ovf = 1;
        end
        r = int'(q);
    endtask

    task automatic start_vec(input int b);
        bus.start = 1'b1;
        bus.bias  = DW'(b);
        tick();
        bus.start = 1'b0;
        chk("in_ready_after_start", bus.in_ready, 1);
    endtask

    task automatic feed(input vec_t d, input vec_t w, input int gap_pct, input int count);
        for (int i = 0; i < count; i++) begin
            for (int g = 0; g < 6 && int'($urandom_range(99)) < gap_pct; g++) begin
                bus.in_valid  = 1'b0;
                bus.in_data   = DW'($urandom);
                bus.in_weight = DW'($urandom);
                tick();
                chk("in_ready_stall", bus.in_ready, 1);
            end
            bus.in_valid  = 1'b1;
            bus.in_data   = DW'(d[i]);
            bus.in_weight = DW'(w[i]);
            chk("in_seg", bus.in_seg, (i >= NX) ? 1 : 0);
            tick();
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int r, input int ovf);
        chk({tag, "_valid"}, bus.out_valid, 1);
        chk({tag, "_data"}, longint'(bus.out_data), r);
        chk({tag, "_ovf"}, bus.out_ovf, ovf);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("retire_valid", bus.out_valid, 0);
        chk("retire_in_ready", bus.in_ready, 0);
    endtask

    task automatic run_vec(input string tag, input int b, input vec_t d, input vec_t w,
                           input int gap_pct);
        int r;
        int ovf;
        model(b, d, w, r, ovf);
        start_vec(b);
        feed(d, w, gap_pct, N);
        expect_result(tag, r, ovf);
        retire();
    endtask

    initial begin
        vec_t d_basic = '{32, 32, 32, 32};
        vec_t w_basic = '{16, 16, 16, 16};
        vec_t d_max   = '{127, 127, 127, 127};
        vec_t w_min   = '{-128, -128, -128, -128};
        vec_t d_p1    = '{1, 0, 0, 0};
        vec_t d_m1    = '{-1, 0, 0, 0};
        vec_t d_r;
        vec_t w_r;
        int   b_r;

        bus.start     = 1'b0;
        bus.bias      = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_weight = '0;
        bus.out_ready = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", longint'(bus.out_data), 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_in_seg", bus.in_seg, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", bus.in_ready, 0);

        // Fixed test-plan vectors
        run_vec("basic", 0, d_basic, w_basic, 0);
        run_vec("sat_pos", 127, d_max, d_max, 0);
        run_vec("sat_neg", -128, d_max, w_min, 0);
        run_vec("floor_p1", 0, d_p1, d_p1, 0);
        run_vec("floor_m1", 0, d_m1, d_p1, 0);
        run_vec("basic_gaps", 0, d_basic, w_basic, 50);

        // Result hold under out_ready=0 with a stray start
        start_vec(0);
        feed(d_basic, w_basic, 0, N);
        for (int c = 0; c < 5; c++) begin
            bus.start = (c == 2);
            bus.bias  = DW'(100);
            expect_result("hold", 64, 0);
            tick();
        end
        bus.start = 1'b0;
        expect_result("hold_end", 64, 0);
        retire();

        // Reset after two accepted elements discards the partial sum
        start_vec(0);
        feed(d_max, d_max, 0, 2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_in_ready", bus.in_ready, 0);
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_data", longint'(bus.out_data), 0);
        chk("mid_rst_out_ovf", bus.out_ovf, 0);
        chk("mid_rst_in_seg", bus.in_seg, 0);
        tick();
        chk("mid_rst_idle", bus.in_ready, 0);
        run_vec("after_rst", 0, d_basic, w_basic, 0);

        // Back-to-back: retire and start in the same cycle
        start_vec(0);
        feed(d_basic, w_basic, 0, N);
        expect_result("b2b_first", 64, 0);
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        bus.bias      = DW'(32);
        tick();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        chk("b2b_in_ready", bus.in_ready, 1);
        chk("b2b_out_valid", bus.out_valid, 0);
        feed(d_basic, w_basic, 0, N);
        expect_result("b2b_second", 96, 0);
        retire();

        // Randomized vectors, alternating small and full-range operands
        for (int k = 0; k < 24; k++) begin
            b_r = int'($urandom_range(255)) - 128;
            for (int i = 0; i < N; i++) begin
                if (k % 2 == 0) begin
                    d_r[i] = int'($urandom_range(31)) - 16;
                    w_r[i] = int'($urandom_range(31)) - 16;
                end else begin
                    d_r[i] = int'($urandom_range(255)) - 128;
                    w_r[i] = int'($urandom_range(255)) - 128;
                end
            end
            run_vec("rand", b_r, d_r, w_r, 30);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
